ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xF4 (enable scanning). It sits beside the keyboard receive path on the same ps2_clk/ps2_data lines and drives them open-drain through output-enable pins. It runs the full request-to-send sequence, shifts out the frame and checks the device acknowledge.

---
 rtl/ps2_host_tx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame shift-out, ACK check.
// Lines are driven open-drain only through the *_oe outputs.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bitcnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic          clk_oe_q, data_oe_q, tx_ready_q, tx_done_q, tx_error_q;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;
    logic fe;
    logic timing;

    // Synchronizers reset to the idle-high line level so reset cannot fake an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    assign fe     = clk_prev_q & ~clk_sync_q;
    assign timing = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
        end else begin
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
            // Timeout wins over a simultaneous falling edge.
            if (timing && cnt_q == TO_LAST) begin
                tx_error_q <= 1'b1;
                clk_oe_q   <= 1'b0;
                data_oe_q  <= 1'b0;
                tx_ready_q <= 1'b1;
                cnt_q      <= '0;
                state_q    <= IDLE;
            end else begin
                if (timing) cnt_q <= fe ? '0 : cnt_q + 1'b1;
                case (state_q)
                    IDLE: begin
                        if (tx_valid && tx_ready_q) begin
                            shift_q    <= tx_data;
                            par_q      <= ~^tx_data;
                            cnt_q      <= '0;
                            clk_oe_q   <= 1'b1;
                            tx_ready_q <= 1'b0;
                            state_q    <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (cnt_q == INH_LAST) begin
                            cnt_q     <= '0;
                            data_oe_q <= 1'b1;
                            state_q   <= START;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    START: begin
                        clk_oe_q <= 1'b0;
                        bitcnt_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= SEND;
                    end
                    SEND: begin
                        if (fe) begin
                            if (bitcnt_q < 4'd8) begin
                                data_oe_q <= ~shift_q[bitcnt_q[2:0]];
                            end else if (bitcnt_q == 4'd8) begin
                                data_oe_q <= ~par_q;
                            end else begin
                                data_oe_q <= 1'b0;
                                state_q   <= ACK;
                            end
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end
                    end
                    ACK: begin
                        if (fe) begin
                            if (!data_sync_q) begin
                                state_q <= WAIT_IDLE;
                            end else begin
                                tx_error_q <= 1'b1;
                                tx_ready_q <= 1'b1;
                                state_q    <= IDLE;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_sync_q && data_sync_q) begin
                            tx_done_q  <= 1'b1;
                            tx_ready_q <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tx_ready    = tx_ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = tx_done_q;
    assign tx_error    = tx_error_q;

endmodule
